// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the pll_cfg reconfiguration sequencer:
// mgmt register map, sequencer states and the write-step index type.
package pll_cfg_pkg;

  localparam logic [5:0] ADDR_MODE  = 6'd0;
  localparam logic [5:0] ADDR_START = 6'd2;
  localparam logic [5:0] ADDR_N     = 6'd3;
  localparam logic [5:0] ADDR_M     = 6'd4;
  localparam logic [5:0] ADDR_C     = 6'd5;
  localparam logic [5:0] ADDR_K     = 6'd7;
  localparam logic [5:0] ADDR_BW    = 6'd8;
  localparam logic [5:0] ADDR_CP    = 6'd9;

  typedef enum logic [2:0] {IDLE, WRITE, PRST, LOCK, DONE} seq_state_t;

  typedef logic [2:0] step_t;

  localparam step_t LAST_STEP = 3'd7;

endpackage

// File: rtl/pll_recfg_seq.sv
// Runs one PLL reprogramming pass: eight mgmt writes with waitrequest
// handshake, a timed PLL reset pulse, then a lock-stability wait with timeout.
module pll_recfg_seq
  import pll_cfg_pkg::*;
#(
  parameter int unsigned RST_CYC     = 8,
  parameter int unsigned LOCK_STABLE = 16,
  parameter int unsigned LOCK_TMO    = 1000000,
  parameter logic [31:0] N_WORD      = 32'h0001_0000,
  parameter logic [31:0] CP_WORD     = 32'd1,
  parameter logic [31:0] BW_WORD     = 32'd7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] cfg_m,
  input  logic [31:0] cfg_k,
  input  logic [31:0] cfg_c0,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        mgmt_write,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        pll_reset
);

  localparam int unsigned TMO_W = $clog2(LOCK_TMO + 1);
  localparam int unsigned STB_W = $clog2(LOCK_STABLE + 1);
  localparam int unsigned RST_W = $clog2(RST_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(LOCK_TMO);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(LOCK_STABLE);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYC - 1);

  seq_state_t       state_q;
  step_t            step_q;
  logic [31:0]      m_q, k_q, c0_q;
  logic [RST_W-1:0] rst_cnt_q;
  logic [STB_W-1:0] stable_q, stable_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             busy_q, done_q, error_q, write_q, pll_reset_q;
  logic [5:0]       addr_q;
  logic [31:0]      data_q;

  // Step table: {address, data} presented for each write step.
  function automatic logic [37:0] step_word(step_t s, logic [31:0] m, logic [31:0] k,
                                            logic [31:0] c0);
    case (s)
      3'd0:    return {ADDR_MODE, 32'd0};
      3'd1:    return {ADDR_M, m};
      3'd2:    return {ADDR_K, k};
      3'd3:    return {ADDR_N, N_WORD};
      3'd4:    return {ADDR_C, c0};
      3'd5:    return {ADDR_CP, CP_WORD};
      3'd6:    return {ADDR_BW, BW_WORD};
      default: return {ADDR_START, 32'd0};
    endcase
  endfunction

  // Saturating lock counters; stable restarts on any low sample.
  always_comb begin
    stable_d = stable_q;
    if (!pll_locked) begin
      stable_d = '0;
    end else if (stable_q != STB_MAX) begin
      stable_d = stable_q + 1'b1;
    end
    tmo_d = (tmo_q != TMO_MAX) ? tmo_q + 1'b1 : tmo_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= '0;
      m_q         <= '0;
      k_q         <= '0;
      c0_q        <= '0;
      rst_cnt_q   <= '0;
      stable_q    <= '0;
      tmo_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      write_q     <= 1'b0;
      pll_reset_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            m_q              <= cfg_m;
            k_q              <= cfg_k;
            c0_q             <= cfg_c0;
            error_q          <= 1'b0;
            busy_q           <= 1'b1;
            step_q           <= '0;
            write_q          <= 1'b1;
            {addr_q, data_q} <= step_word(3'd0, cfg_m, cfg_k, cfg_c0);
            state_q          <= WRITE;
          end
        end
        WRITE: begin
          if (!mgmt_waitrequest) begin
            if (step_q == LAST_STEP) begin
              write_q     <= 1'b0;
              addr_q      <= '0;
              data_q      <= '0;
              pll_reset_q <= 1'b1;
              rst_cnt_q   <= '0;
              state_q     <= PRST;
            end else begin
              step_q           <= step_q + 3'd1;
              {addr_q, data_q} <= step_word(step_q + 3'd1, m_q, k_q, c0_q);
            end
          end
        end
        PRST: begin
          if (rst_cnt_q == RST_LAST) begin
            pll_reset_q <= 1'b0;
            stable_q    <= '0;
            tmo_q       <= '0;
            state_q     <= LOCK;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        LOCK: begin
          stable_q <= stable_d;
          tmo_q    <= tmo_d;
          // Stable lock is checked first so it wins over a same-cycle timeout.
          if (stable_d == STB_MAX) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
            state_q <= DONE;
          end else if (tmo_d == TMO_MAX) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign mgmt_address   = addr_q;
  assign mgmt_writedata = data_q;
  assign mgmt_write     = write_q;
  assign pll_reset      = pll_reset_q;

endmodule
